// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory responder with programmable wait states and a one-cycle DONE pulse.
// Optional feature macro MEM_RANGE_CHECK_EN: flag accesses at or above DEPTH with ERR and suppress them.
module mem_responder #(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_WIDTH-1:0] ADDR,
   input  logic [DATA_WIDTH-1:0] DATA_W,
   output logic [DATA_WIDTH-1:0] DATA_R,
   output logic                  READY,
   output logic                  DONE,
   output logic                  ERR
);

   localparam int         IDX_WIDTH = $clog2(DEPTH);
   localparam bit         HAS_WAIT  = (LATENCY > 0);
   localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic [3:0]            cnt_r;
   logic [3:0]            cnt_next_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic                  we_r;
   logic [DATA_WIDTH-1:0] data_r_r;
   logic                  ready_r;
   logic                  done_r;
   logic                  err_r;
   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   logic                  accept_s;
   logic                  commit_s;
   logic                  commit_we_s;
   logic                  commit_oor_s;
   logic [ADDR_WIDTH-1:0] commit_addr_s;
   logic [DATA_WIDTH-1:0] commit_data_s;
   logic [IDX_WIDTH-1:0]  commit_idx_s;

`ifdef MEM_RANGE_CHECK_EN
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   function automatic logic addr_out_of_range(input logic [ADDR_WIDTH-1:0] addr);
      return ({1'b0, addr} >= DEPTH_EXT);
   endfunction

   assign commit_oor_s = addr_out_of_range(commit_addr_s);
`else
   assign commit_oor_s = 1'b0;
   if (IDX_WIDTH < ADDR_WIDTH) begin : g_upper_unused
      logic unused_upper_s;
      assign unused_upper_s = ^commit_addr_s[ADDR_WIDTH-1:IDX_WIDTH];
   end
`endif

   // Next-state and wait-counter decode.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      accept_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (READ ^ WRITE) begin
               accept_s = 1'b1;
               if (HAS_WAIT) begin
                  state_next_s = ST_WAIT;
                  cnt_next_s   = WAIT_LOAD;
               end else begin
                  state_next_s = ST_RESP;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_next_s = ST_RESP;
            end else begin
               cnt_next_s = cnt_r - 4'd1;
            end
         end
         ST_RESP: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
            cnt_next_s   = 4'd0;
         end
      endcase
   end

   // With zero wait states the commit happens on the accept edge, so the live inputs are the source.
   always_comb begin
      commit_addr_s = addr_r;
      commit_data_s = wdata_r;
      commit_we_s   = we_r;
      if (state_r == ST_IDLE) begin
         commit_addr_s = ADDR;
         commit_data_s = DATA_W;
         commit_we_s   = WRITE;
      end else begin
         commit_addr_s = addr_r;
         commit_data_s = wdata_r;
         commit_we_s   = we_r;
      end
   end

   assign commit_s     = (state_next_s == ST_RESP) && (state_r != ST_RESP) && !RST;
   assign commit_idx_s = commit_addr_s[IDX_WIDTH-1:0];

   // Control state, request latches and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 4'd0;
         addr_r   <= {ADDR_WIDTH{1'b0}};
         wdata_r  <= {DATA_WIDTH{1'b0}};
         we_r     <= 1'b0;
         data_r_r <= {DATA_WIDTH{1'b0}};
         ready_r  <= 1'b1;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         if (accept_s) begin
            addr_r  <= ADDR;
            wdata_r <= DATA_W;
            we_r    <= WRITE;
         end
         ready_r <= (state_next_s == ST_IDLE);
         done_r  <= commit_s;
         err_r   <= commit_s & commit_oor_s;
         if (commit_s && !commit_we_s) begin
            data_r_r <= commit_oor_s ? {DATA_WIDTH{1'b0}} : mem_r[commit_idx_s];
         end
      end
   end

   // Storage array; deliberately not cleared by reset.
   always_ff @(posedge CLK) begin
      if (commit_s && commit_we_s && !commit_oor_s) begin
         mem_r[commit_idx_s] <= commit_data_s;
      end
   end

   assign DATA_R = data_r_r;
   assign READY  = ready_r;
   assign DONE   = done_r;
   assign ERR    = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench driving three mem_responder instances (LATENCY 2, 0, 3) in lockstep.
module tb_mem_responder;

   localparam int AW    = 26;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int NI    = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          rd;
   logic          wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_w;
   logic [DW-1:0] data_r [NI];
   logic          ready  [NI];
   logic          done   [NI];
   logic          err    [NI];

   int lat [NI] = '{2, 0, 3};

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_responder #(
         .ADDR_WIDTH(AW),
         .DATA_WIDTH(DW),
         .DEPTH(DEPTH),
         .LATENCY((g == 0) ? 2 : ((g == 1) ? 0 : 3))
      ) u_dut (
         .CLK(clk),
         .RST(rst),
         .READ(rd),
         .WRITE(wr),
         .ADDR(addr),
         .DATA_W(data_w),
         .DATA_R(data_r[g]),
         .READY(ready[g]),
         .DONE(done[g]),
         .ERR(err[g])
      );
   end

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
      int            due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   logic [DW-1:0] mdl     [NI][DEPTH];
   logic [DW-1:0] last_rd [NI];
   int            busy    [NI];
   int            cyc = 0;
   int            n_checks = 0;
   int            n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic int q_size(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic q_push(input int i, input exp_t e);
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic q_pop(input int i, output exp_t e);
      case (i)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
   endtask

   // Reference model: update model array and push the expected completion for instance i.
   task automatic model_push(input int i, input logic is_wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int acc);
      exp_t       e;
      logic       oor;
      logic [9:0] idx;
      idx = a[9:0];
`ifdef MEM_RANGE_CHECK_EN
      oor = (a >= AW'(DEPTH));
`else
      oor = 1'b0;
`endif
      e.err = oor;
      e.due = acc + lat[i];
      if (is_wr) begin
         if (!oor) mdl[i][idx] = d;
         e.data = last_rd[i];
      end else begin
         e.data = oor ? 32'h0 : mdl[i][idx];
         last_rd[i] = e.data;
      end
      q_push(i, e);
   endtask

   function automatic logic all_idle();
      logic r;
      r = 1'b1;
      for (int i = 0; i < NI; i++) begin
         if (ready[i] !== 1'b1 || q_size(i) != 0) r = 1'b0;
      end
      return r;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while (!all_idle() && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check_eq("idle_timeout", 32'(n), 32'd0);
   endtask

   task automatic issue(input logic is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic inject);
      wait_idle();
      for (int i = 0; i < NI; i++) check_eq($sformatf("held_data_r[%0d]", i), data_r[i], last_rd[i]);
      rd = !is_wr;
      wr = is_wr;
      addr = a;
      data_w = d;
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) model_push(i, is_wr, a, d, cyc);
      if (inject) begin
         rd = 1'b0;
         wr = 1'b1;
         data_w = ~d;
         @(posedge clk); #1;
      end
      rd = 1'b0;
      wr = 1'b0;
      addr = AW'($urandom);
      data_w = $urandom;
   endtask

   // Completion monitor: READY-low length, spurious DONE, latency, data and error flag.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < NI; i++) begin
         if (rst === 1'b1) begin
            busy[i] = 0;
         end else if (ready[i] === 1'b0) begin
            busy[i]++;
         end else if (busy[i] != 0) begin
            check_eq($sformatf("busy_len[%0d]", i), 32'(busy[i]), 32'(lat[i] + 1));
            busy[i] = 0;
         end
         if (done[i] === 1'b1) begin
            if (q_size(i) == 0) begin
               check_eq($sformatf("unexpected_done[%0d]", i), 32'(q_size(i)), 32'd1);
            end else begin
               q_pop(i, e);
               check_eq($sformatf("done_cycle[%0d]", i), 32'(cyc), 32'(e.due));
               check_eq($sformatf("ready_in_resp[%0d]", i), {31'd0, ready[i]}, 32'd0);
               check_eq($sformatf("data_r[%0d]", i), data_r[i], e.data);
               check_eq($sformatf("err[%0d]", i), {31'd0, err[i]}, {31'd0, e.err});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rdat;
      rst = 1'b1;
      rd = 1'b0;
      wr = 1'b0;
      addr = '0;
      data_w = '0;
      for (int i = 0; i < NI; i++) last_rd[i] = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         check_eq($sformatf("rst_ready[%0d]", i), {31'd0, ready[i]}, 32'd1);
         check_eq($sformatf("rst_done[%0d]", i), {31'd0, done[i]}, 32'd0);
         check_eq($sformatf("rst_err[%0d]", i), {31'd0, err[i]}, 32'd0);
         check_eq($sformatf("rst_data_r[%0d]", i), data_r[i], 32'h0);
      end

      issue(1'b1, 26'h0, 32'h0BADF00D, 1'b0);
      issue(1'b1, 26'h10, 32'hDEADBEEF, 1'b0);
      issue(1'b0, 26'h10, 32'h0, 1'b0);
      issue(1'b1, 26'h5, 32'h00001234, 1'b0);
      issue(1'b0, 26'h5, 32'h0, 1'b0);

      // Both strobes together in IDLE must be ignored.
      wait_idle();
      rd = 1'b1;
      wr = 1'b1;
      addr = 26'h10;
      data_w = 32'hFFFFFFFF;
      @(posedge clk); #1;
      rd = 1'b0;
      wr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < NI; i++) check_eq($sformatf("illegal_ready[%0d]", i), {31'd0, ready[i]}, 32'd1);
         @(posedge clk); #1;
      end
      issue(1'b0, 26'h10, 32'h0, 1'b0);

      // A write strobed while busy must not reach the array.
      issue(1'b1, 26'h30, 32'h11111111, 1'b1);
      issue(1'b0, 26'h30, 32'h0, 1'b0);

      // Reset on the second WAIT cycle of the LATENCY=3 instance; only LATENCY=0 has committed by then.
      issue(1'b1, 26'h20, 32'h13579BDF, 1'b0);
      wait_idle();
      wr = 1'b1;
      addr = 26'h20;
      data_w = 32'hCAFEF00D;
      @(posedge clk); #1;
      model_push(1, 1'b1, 26'h20, 32'hCAFEF00D, cyc);
      wr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         last_rd[i] = 32'h0;
         check_eq($sformatf("midrst_ready[%0d]", i), {31'd0, ready[i]}, 32'd1);
         check_eq($sformatf("midrst_data_r[%0d]", i), data_r[i], 32'h0);
      end
      issue(1'b0, 26'h20, 32'h0, 1'b0);

      // Address DEPTH: wraps to word 0, or is flagged when range checking is built in.
      issue(1'b1, 26'h400, 32'hA5A5A5A5, 1'b0);
      issue(1'b0, 26'h0, 32'h0, 1'b0);
      issue(1'b0, 26'h400, 32'h0, 1'b0);

      for (int k = 0; k < 8; k++) begin
         ra = 26'($urandom_range(64, 127));
         rdat = $urandom;
         issue(1'b1, ra, rdat, 1'b0);
         issue(1'b0, ra, 32'h0, 1'b0);
      end

      wait_idle();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor data path's memory interface.
- Accepts word read/write requests (ADDR, write data, READ/WRITE strobes), inserts a programmable number of wait states, then completes with a one-cycle DONE pulse.
- Read data is held stable until the next read completes.
- Serves as the main memory model behind the processor's ADDR/DATA_OUT/DATA_IN bus and as the base for a later synthesizable memory controller.

Parameters:
- ADDR_WIDTH, 26, request address width (word address).
- DATA_WIDTH, 32, data word width.
- DEPTH, 1024, number of stored words; must be a power of two, 2..2^ADDR_WIDTH.
- LATENCY, 2, wait-state cycles between accept and completion; legal range 0..15.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-high.
- READ  input  1  read request strobe; sampled only while READY=1.
- WRITE  input  1  write request strobe; sampled only while READY=1.
- ADDR  input  ADDR_WIDTH  word address; sampled at accept.
- DATA_W  input  DATA_WIDTH  write data from the processor; sampled at accept.
- DATA_R  output  DATA_WIDTH  read data to the processor; registered.
- READY  output  1  responder idle and able to accept a request.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  error flag, valid only while DONE=1.

Behaviour:
- Reset: synchronous, active-high, one clock, CLK/RST named as above. Rising edge with RST=1 forces state IDLE, READY=1, DONE=0, ERR=0, DATA_R=0, wait counter=0. Memory array contents are not cleared.
- Reset mid-operation: the request is aborted and no DONE is produced. A write is dropped unless it has already committed, i.e. it reached RESP before the reset edge.
- States:
  - IDLE (READY=1).
  - WAIT (READY=0, counter running).
  - RESP (READY=0, DONE=1).
- Accept: an edge in IDLE with exactly one of READ/WRITE high latches ADDR, DATA_W and the op.
  - LATENCY>0: next state WAIT, counter loaded with LATENCY-1.
  - LATENCY=0: next state RESP directly.
- READ=1 and WRITE=1 together in IDLE: illegal. Ignored, stays IDLE, no DONE, no array access.
- WAIT: counter decrements each edge. The edge where the counter is 0 moves to RESP.
- Commit: the edge entering RESP performs the access.
  - Write: stores the latched data to the array.
  - Read: loads DATA_R from the array.
- RESP lasts exactly one cycle (DONE=1), then returns to IDLE.
- Timing: READY is low for LATENCY+1 cycles per request. Back-to-back requests are possible: accept again on the first cycle READY is back high. The minimum request period is LATENCY+2 cycles.
- READ/WRITE/ADDR/DATA_W are don't-care while READY=0. Requests presented while busy are not queued.
- DATA_R changes only on a read commit or reset. Write completions leave DATA_R unchanged.
- A read of a word written by the immediately preceding request returns the new value.
- Address mapping: word index = ADDR[log2(DEPTH)-1:0]. Without range checking, higher bits wrap.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined: a latched ADDR >= DEPTH completes normally in timing (same DONE cycle) with ERR=1.
  - Write is discarded; the array is unchanged.
  - Read loads DATA_R=0.
- Undefined: no range check. ERR is tied to 0; the address wraps modulo DEPTH.

Test Plan:
- Reset then idle: assert RST for 1 edge -> READY=1, DONE=0, ERR=0, DATA_R=0x00000000 on the following cycle.
- Write/read, LATENCY=2: WRITE ADDR=0x10 DATA_W=0xDEADBEEF -> READY low 3 cycles, DONE high exactly on the 3rd cycle after accept. Then READ ADDR=0x10 -> DONE pulse with DATA_R=0xDEADBEEF, held after DONE falls.
- LATENCY=0 back-to-back: WRITE 0x5=0x1234 then READ 0x5 on the next READY cycle -> each DONE one cycle after accept; DATA_R=0x00001234.
- Illegal/busy inputs: READ=WRITE=1 in IDLE -> no DONE, READY stays 1. WRITE strobed while READY=0 -> ignored; the array word is unchanged on readback.
- Reset mid-op: WRITE 0x20=0xCAFEF00D (LATENCY=3), RST on the 2nd WAIT cycle -> no DONE. Readback of 0x20 returns the prior value.
- Range check: with MEM_RANGE_CHECK_EN, READ ADDR=DEPTH (0x400) -> DONE=1, ERR=1, DATA_R=0. Without the macro, WRITE 0x400=0xA5A5A5A5 then READ 0x0 -> DATA_R=0xA5A5A5A5, ERR=0.
